// File: rtl/nios_cpu_pio_pkg.sv
// Shared constants for the PIO edge-capture input block: register word
// addresses and the arming delay applied after reset release.
package nios_cpu_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_EDGE_POL = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;

    // Edge detection stays off until the arm counter reaches this value.
    typedef logic [1:0] arm_cnt_t;
    localparam arm_cnt_t ARM_CYCLES = 2'd3;

endpackage

// File: rtl/nios_cpu_pio_edge_in_if.sv
// Avalon-MM slave bus for the PIO edge-capture block.
//
// Handshake: there is no waitrequest, so the slave is always ready. A write
// is accepted on the rising clk edge where chipselect=1 and write_n=0. A
// read is any cycle with chipselect=1; readdata holds the addressed value
// one clk later. With chipselect=0 readdata returns 0 on the next edge.
interface nios_cpu_pio_edge_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios_cpu_pio_sync_edge.sv
// One input bit: two-flop synchronizer (s1, s2), a delay flop (s3) and a
// polarity-selected single-cycle edge pulse derived from s2/s3.
module nios_cpu_pio_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d_in,
    input  logic edge_pol,   // 0 = rising, 1 = falling
    output logic sync_out,
    output logic edge_pulse
);
    logic s1, s2, s3;

    // Synchronize the asynchronous input and keep one cycle of history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync_out   = s2;
    assign edge_pulse = edge_pol ? (~s2 & s3) : (s2 & ~s3);
endmodule

// File: rtl/nios_cpu_pio_edge_in.sv
// PIO input port with per-bit edge capture, interrupt mask and sticky
// write-1-to-clear capture register behind an Avalon-MM slave.
module nios_cpu_pio_edge_in
    import nios_cpu_pio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       in_port,
    nios_cpu_pio_edge_in_if.slave  bus
);
    logic [WIDTH-1:0] data_sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edge_pol;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clear;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      wdata_unused;
    logic [31:0]      rd_mux;
    arm_cnt_t         arm_cnt;
    logic             armed;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_cpu_pio_sync_edge u_sync_edge (
            .clk        (clk),
            .reset_n    (reset_n),
            .d_in       (in_port[i]),
            .edge_pol   (edge_pol[i]),
            .sync_out   (data_sync[i]),
            .edge_pulse (edge_pulse[i])
        );
    end

    // Only the low WIDTH write bits reach a register; the rest are dropped.
    assign wdata_unused = bus.writedata;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign armed        = (arm_cnt == ARM_CYCLES);
    assign cap_clear    = (wr_en && bus.address == ADDR_EDGE_CAP) ? wdata : '0;

    // Arm counter: saturates so edges are ignored while the synchronizer fills.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            arm_cnt <= '0;
        else if (!armed)
            arm_cnt <= arm_cnt + 2'd1;
    end

    // Control registers written from the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_pol <= '0;
            irq_mask <= '0;
        end else if (wr_en) begin
            if (bus.address == ADDR_EDGE_POL) edge_pol <= wdata;
            if (bus.address == ADDR_IRQ_MASK) irq_mask <= wdata;
        end
    end

    // Sticky capture: a detected edge beats a same-cycle clear on that bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            edge_cap <= '0;
        else
            edge_cap <= (edge_cap & ~cap_clear) | (edge_pulse & {WIDTH{armed}});
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:     rd_mux[WIDTH-1:0] = data_sync;
            ADDR_EDGE_POL: rd_mux[WIDTH-1:0] = edge_pol;
            ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
            default:       rd_mux = '0;
        endcase
    end

    // Registered read data; zero whenever the slave is not selected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.readdata <= '0;
        else
            bus.readdata <= bus.chipselect ? rd_mux : 32'd0;
    end

    assign bus.irq = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_nios_cpu_pio_edge_in.sv
// Directed bench for nios_cpu_pio_edge_in (WIDTH = 8).
module tb_nios_cpu_pio_edge_in;
    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] in_port;
    int               n_tests;
    int               n_fail;
    logic [31:0]      rd;

    nios_cpu_pio_edge_in_if bus ();

    nios_cpu_pio_edge_in #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = addr;
        bus.writedata  = data;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = addr;
        @(negedge clk);
        data = bus.readdata;
        bus_idle();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus_idle();
        in_port = 8'hFF;
        reset_n = 1'b0;
        wait_cycles(3);
        n_tests++;
        if (bus.readdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_readdata: got %h want %h", bus.readdata, 32'd0);
        end
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b want 0", bus.irq);
        end
        reset_n = 1'b1;
        wait_cycles(10);
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL reset_high_no_cap: got %h want %h", rd, 32'd0);
        end
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_high_irq: got %b want 0", bus.irq);
        end
        bus_read(3'd0, rd);
        n_tests++;
        if (rd !== 32'h0000_00FF) begin
            n_fail++; $display("FAIL reset_data_read: got %h want %h", rd, 32'h0000_00FF);
        end
        bus_read(3'd1, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL reset_edge_pol: got %h want %h", rd, 32'd0);
        end
    endtask

    task automatic test_rise_capture();
        bus_write(3'd2, 32'h01);
        bus_write(3'd1, 32'h00);
        in_port = 8'h00;           // falling edges under rising polarity: ignored
        wait_cycles(6);
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL rise_no_fall_cap: got %h want %h", rd, 32'd0);
        end
        in_port = 8'h01;           // set up before edge k
        @(posedge clk);            // edge k
        @(negedge clk);
        @(posedge clk);            // edge k+1
        @(negedge clk);
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL rise_irq_early: got %b want 0", bus.irq);
        end
        @(posedge clk);            // edge k+2
        @(negedge clk);
        n_tests++;
        if (bus.irq !== 1'b1) begin
            n_fail++; $display("FAIL rise_irq_set: got %b want 1", bus.irq);
        end
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'h01) begin
            n_fail++; $display("FAIL rise_cap: got %h want %h", rd, 32'h01);
        end
        bus_read(3'd3, rd);        // reading must not clear
        n_tests++;
        if (rd !== 32'h01) begin
            n_fail++; $display("FAIL rise_read_no_clear: got %h want %h", rd, 32'h01);
        end
        bus_write(3'd3, 32'h01);
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL rise_irq_clear: got %b want 0", bus.irq);
        end
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL rise_cap_clear: got %h want %h", rd, 32'd0);
        end
    endtask

    task automatic test_fall_capture();
        bus_write(3'd1, 32'h80);
        in_port = 8'h81;           // bit7 rises: no capture under falling polarity
        wait_cycles(6);
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL fall_no_rise_cap: got %h want %h", rd, 32'd0);
        end
        in_port = 8'h01;           // bit7 falls
        wait_cycles(6);
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'h80) begin
            n_fail++; $display("FAIL fall_cap: got %h want %h", rd, 32'h80);
        end
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL fall_irq_masked: got %b want 0", bus.irq);
        end
        bus_write(3'd1, 32'h00);   // polarity change keeps captured bits
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'h80) begin
            n_fail++; $display("FAIL pol_change_keeps_cap: got %h want %h", rd, 32'h80);
        end
        bus_write(3'd3, 32'h80);
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL fall_cap_clear: got %h want %h", rd, 32'd0);
        end
    endtask

    task automatic test_set_clear_collision();
        in_port = 8'h05;           // bit2 rises, set up before edge k
        @(posedge clk);            // edge k
        @(negedge clk);
        @(posedge clk);            // edge k+1
        bus_write(3'd3, 32'h04);   // write lands on edge k+2, same as the capture
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'h04) begin
            n_fail++; $display("FAIL collision_set_wins: got %h want %h", rd, 32'h04);
        end
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL collision_irq_masked: got %b want 0", bus.irq);
        end
        bus_write(3'd3, 32'h04);
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL collision_clear_after: got %h want %h", rd, 32'd0);
        end
    endtask

    task automatic test_mask_and_partial_clear();
        in_port = 8'h35;           // bits 4 and 5 rise
        wait_cycles(6);
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'h30) begin
            n_fail++; $display("FAIL mask_cap_30: got %h want %h", rd, 32'h30);
        end
        bus_write(3'd2, 32'h0F);
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL mask_0f_irq: got %b want 0", bus.irq);
        end
        bus_write(3'd2, 32'h10);
        n_tests++;
        if (bus.irq !== 1'b1) begin
            n_fail++; $display("FAIL mask_10_irq: got %b want 1", bus.irq);
        end
        bus_write(3'd3, 32'h10);
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL partial_clear_irq: got %b want 0", bus.irq);
        end
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'h20) begin
            n_fail++; $display("FAIL partial_clear_cap: got %h want %h", rd, 32'h20);
        end
    endtask

    task automatic test_unused_addr();
        for (int a = 4; a < 8; a++) begin
            bus_write(3'(a), 32'hFFFF_FFFF);
            bus_read(3'(a), rd);
            n_tests++;
            if (rd !== 32'd0) begin
                n_fail++; $display("FAIL unused_addr_%0d: got %h want %h", a, rd, 32'd0);
            end
        end
        bus_write(3'd0, 32'h0000_0000);   // data register is read-only
        bus_read(3'd0, rd);
        n_tests++;
        if (rd !== 32'h35) begin
            n_fail++; $display("FAIL unused_data: got %h want %h", rd, 32'h35);
        end
        bus_read(3'd1, rd);
        n_tests++;
        if (rd !== 32'h00) begin
            n_fail++; $display("FAIL unused_edge_pol: got %h want %h", rd, 32'h00);
        end
        bus_read(3'd2, rd);
        n_tests++;
        if (rd !== 32'h10) begin
            n_fail++; $display("FAIL unused_irq_mask: got %h want %h", rd, 32'h10);
        end
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'h20) begin
            n_fail++; $display("FAIL unused_edge_cap: got %h want %h", rd, 32'h20);
        end
        wait_cycles(2);                   // deselected: readdata returns 0
        n_tests++;
        if (bus.readdata !== 32'd0) begin
            n_fail++; $display("FAIL deselect_readdata: got %h want %h", bus.readdata, 32'd0);
        end
    endtask

    task automatic test_upper_bits();
        bus_write(3'd1, 32'hFFFF_FF00);
        bus_read(3'd1, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL upper_bits_ignored: got %h want %h", rd, 32'd0);
        end
    endtask

    task automatic test_reset_mid();
        bus_write(3'd2, 32'h20);
        n_tests++;
        if (bus.irq !== 1'b1) begin
            n_fail++; $display("FAIL mid_irq_before: got %b want 1", bus.irq);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;                // asynchronous, away from any edge
        #1;
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL mid_irq_async_clear: got %b want 0", bus.irq);
        end
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(10);
        bus_read(3'd3, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL mid_cap_after: got %h want %h", rd, 32'd0);
        end
        bus_read(3'd2, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL mid_mask_after: got %h want %h", rd, 32'd0);
        end
        bus_read(3'd0, rd);
        n_tests++;
        if (rd !== 32'h35) begin
            n_fail++; $display("FAIL mid_data_after: got %h want %h", rd, 32'h35);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_rise_capture();
        test_fall_capture();
        test_set_clear_collision();
        test_mask_and_partial_clear();
        test_unused_addr();
        test_upper_bits();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
